// File: rtl/sr_latch_monitor.sv
// sr_latch_monitor: response-side checker that models a set/reset latch and flags q/qbar errors after a settle window.
// Ports: clk, rst_n (async active-low); set/reset = active-high latch drive; q/qbar = latch outputs (async to clk);
// clr_err = sync clear of error state; busy = settling; exp_q = model q; illegal = set and reset both high;
// err_pulse/err_sticky/err_cnt = error reporting; toggle_cnt = edges on synced q.
// Optional SR_MON_FIRST_ERR_EN adds first_err_time/first_err_kind capture of the first failing cycle.
module sr_latch_monitor #(
    parameter int SETTLE_CYC = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set,
    input  logic             reset,
    input  logic             q,
    input  logic             qbar,
    input  logic             clr_err,
    output logic             busy,
    output logic             exp_q,
    output logic             illegal,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt,
`ifdef SR_MON_FIRST_ERR_EN
    output logic [15:0]      first_err_time,
    output logic [1:0]       first_err_kind,
`endif
    output logic [CNT_W-1:0] toggle_cnt
);
    typedef enum logic {SETTLE, MONITOR} state_t;
    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic q_m_q, q_m_d, q_s_q, q_s_d, qbar_m_q, qbar_m_d, qbar_s_q, qbar_s_d;
    logic set_r_q, set_r_d, reset_r_q, reset_r_d;
    logic exp_q_q, exp_q_d, exp_valid_q, exp_valid_d, illegal_q, illegal_d;
    logic err_pulse_q, err_pulse_d, err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d, toggle_cnt_q, toggle_cnt_d;
    logic change, mismatch, compl_err, fail;
`ifdef SR_MON_FIRST_ERR_EN
    logic [15:0] cyc_q, cyc_d, ftime_q, ftime_d;
    logic [1:0]  fkind_q, fkind_d;
`endif
    always_comb begin
        change       = {set, reset} != {set_r_q, reset_r_q};
        // compare against the registered model; q=qbar is legitimate while the model is invalid (after 11)
        mismatch     = (state_q == MONITOR) & exp_valid_q & (q_s_q != exp_q_q);
        compl_err    = (state_q == MONITOR) & exp_valid_q & (q_s_q == qbar_s_q);
        fail         = mismatch | compl_err;
        q_m_d        = q;
        q_s_d        = q_m_q;
        qbar_m_d     = qbar;
        qbar_s_d     = qbar_m_q;
        set_r_d      = set;
        reset_r_d    = reset;
        exp_q_d      = (set_r_q & ~reset_r_q) ? 1'b1 : (~set_r_q & reset_r_q) ? 1'b0 : exp_q_q;
        exp_valid_d  = (set_r_q ^ reset_r_q) ? 1'b1 : (set_r_q & reset_r_q) ? 1'b0 : exp_valid_q;
        illegal_d    = set_r_q & reset_r_q;
        state_d      = change ? SETTLE : (state_q == SETTLE && cnt_q <= 8'd1) ? MONITOR : state_q;
        cnt_d        = change ? 8'(SETTLE_CYC) : (state_q == SETTLE && cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
        err_pulse_d  = fail;
        err_sticky_d = clr_err ? 1'b0 : err_sticky_q | fail;
        err_cnt_d    = clr_err ? '0 : (fail & ~&err_cnt_q) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
        // q_m differs from q_s exactly when q_s is about to change
        toggle_cnt_d = toggle_cnt_q + CNT_W'(q_m_q ^ q_s_q);
`ifdef SR_MON_FIRST_ERR_EN
        cyc_d        = &cyc_q ? cyc_q : cyc_q + 16'd1;
        // a zero kind means nothing captured yet
        fkind_d      = clr_err ? 2'b00 : (fail && fkind_q == 2'b00) ? {compl_err, mismatch} : fkind_q;
        ftime_d      = clr_err ? 16'd0 : (fail && fkind_q == 2'b00) ? cyc_q : ftime_q;
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SETTLE;
            cnt_q        <= 8'(SETTLE_CYC);
            q_m_q        <= 1'b0;
            q_s_q        <= 1'b0;
            qbar_m_q     <= 1'b1;
            qbar_s_q     <= 1'b1;
            set_r_q      <= 1'b0;
            reset_r_q    <= 1'b0;
            exp_q_q      <= 1'b0;
            exp_valid_q  <= 1'b1;
            illegal_q    <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
            toggle_cnt_q <= '0;
`ifdef SR_MON_FIRST_ERR_EN
            cyc_q        <= 16'd0;
            ftime_q      <= 16'd0;
            fkind_q      <= 2'b00;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            q_m_q        <= q_m_d;
            q_s_q        <= q_s_d;
            qbar_m_q     <= qbar_m_d;
            qbar_s_q     <= qbar_s_d;
            set_r_q      <= set_r_d;
            reset_r_q    <= reset_r_d;
            exp_q_q      <= exp_q_d;
            exp_valid_q  <= exp_valid_d;
            illegal_q    <= illegal_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
            toggle_cnt_q <= toggle_cnt_d;
`ifdef SR_MON_FIRST_ERR_EN
            cyc_q        <= cyc_d;
            ftime_q      <= ftime_d;
            fkind_q      <= fkind_d;
`endif
        end
    end
    assign busy       = state_q == SETTLE;
    assign exp_q      = exp_q_q;
    assign illegal    = illegal_q;
    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;
    assign toggle_cnt = toggle_cnt_q;
`ifdef SR_MON_FIRST_ERR_EN
    assign first_err_time = ftime_q;
    assign first_err_kind = fkind_q;
`endif
endmodule

// File: tb/tb_sr_latch_monitor.sv
// tb_sr_latch_monitor: random and directed checks of sr_latch_monitor against a cycle-level reference model.
module tb_sr_latch_monitor;
    localparam int SC = 4;
    logic clk = 1'b0, rst_n = 1'b0, set = 1'b0, reset = 1'b0, q = 1'b0, qbar = 1'b1, clr_err = 1'b0;
    logic busy, exp_q, illegal, err_pulse, err_sticky;
    logic [7:0] err_cnt, toggle_cnt;
`ifdef SR_MON_FIRST_ERR_EN
    logic [15:0] first_err_time;
    logic [1:0]  first_err_kind;
`endif
    sr_latch_monitor #(.SETTLE_CYC(SC), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .set(set), .reset(reset), .q(q), .qbar(qbar), .clr_err(clr_err),
        .busy(busy), .exp_q(exp_q), .illegal(illegal), .err_pulse(err_pulse), .err_sticky(err_sticky),
        .err_cnt(err_cnt),
`ifdef SR_MON_FIRST_ERR_EN
        .first_err_time(first_err_time), .first_err_kind(first_err_kind),
`endif
        .toggle_cnt(toggle_cnt)
    );
    always #5 clk = ~clk;
    int n_vec = 0, n_err = 0;
    int mode = 0;
    logic lq = 1'b0;
    logic m_sr, m_rr, m_q1, m_qs, m_qb1, m_qbs, m_exp, m_valid, m_ill, m_ep, m_sticky;
    int m_since, m_cnt, m_tog, m_cyc, m_ftime, m_fkind;
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask
    task automatic m_reset();
        m_sr = 0; m_rr = 0; m_q1 = 0; m_qs = 0; m_qb1 = 1; m_qbs = 1;
        m_exp = 0; m_valid = 1; m_ill = 0; m_ep = 0; m_sticky = 0;
        m_since = 0; m_cnt = 0; m_tog = 0; m_cyc = 0; m_ftime = 0; m_fkind = 0;
    endtask
    // bench latch: mode 0 correct, 1 q stuck at 0, 2 both outputs inverted
    task automatic drive();
        logic cq, cqb;
        cq  = (set && reset) ? 1'b1 : lq;
        cqb = (set && reset) ? 1'b1 : ~lq;
        q    = (mode == 1) ? 1'b0 : (mode == 2) ? ~cq : cq;
        qbar = (mode == 2) ? ~cqb : cqb;
    endtask
    task automatic apply(input logic s, input logic r);
        set = s; reset = r;
        if (s && !r) lq = 1'b1;
        else if (r && !s) lq = 1'b0;
        drive();
    endtask
    task automatic check_all();
        chk("busy", busy, (m_since < SC) ? 1 : 0);
        chk("exp_q", exp_q, m_exp);
        chk("illegal", illegal, m_ill);
        chk("err_pulse", err_pulse, m_ep);
        chk("err_sticky", err_sticky, m_sticky);
        chk("err_cnt", err_cnt, m_cnt);
        chk("toggle_cnt", toggle_cnt, m_tog);
`ifdef SR_MON_FIRST_ERR_EN
        chk("first_err_time", first_err_time, m_ftime);
        chk("first_err_kind", first_err_kind, m_fkind);
`endif
    endtask
    task automatic tick();
        logic mis, cmp, fail, chg, cs, cr, cq, cqb, cc;
        mis  = (m_since >= SC) && m_valid && (m_qs != m_exp);
        cmp  = (m_since >= SC) && m_valid && (m_qs == m_qbs);
        fail = mis || cmp;
        chg  = {set, reset} != {m_sr, m_rr};
        cs = set; cr = reset; cq = q; cqb = qbar; cc = clr_err;
        @(posedge clk);
        m_ep = fail;
        if (cc) begin
            m_cnt = 0; m_sticky = 0; m_ftime = 0; m_fkind = 0;
        end else if (fail) begin
            m_sticky = 1;
            if (m_cnt < 255) m_cnt++;
            if (m_fkind == 0) begin
                m_fkind = (cmp ? 2 : 0) + (mis ? 1 : 0);
                m_ftime = m_cyc;
            end
        end
        if (m_cyc < 65535) m_cyc++;
        if (m_q1 != m_qs) m_tog = (m_tog + 1) % 256;
        m_qs = m_q1; m_q1 = cq; m_qbs = m_qb1; m_qb1 = cqb;
        if (m_sr && !m_rr) begin m_exp = 1; m_valid = 1; end
        else if (!m_sr && m_rr) begin m_exp = 0; m_valid = 1; end
        else if (m_sr && m_rr) m_valid = 0;
        m_ill = m_sr && m_rr;
        m_sr = cs; m_rr = cr;
        m_since = chg ? 0 : (m_since < 1000 ? m_since + 1 : m_since);
        #1 check_all();
    endtask
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask
    initial begin
        m_reset();
        #23 check_all();
        @(posedge clk); #1 rst_n = 1'b1;
        ticks(3);
        chk("busy_before4", busy, 1);
        tick();
        chk("busy_after4", busy, 0);
        chk("exp_q_idle", exp_q, 0);
        apply(1, 0); ticks(10);
        chk("exp_q_set", exp_q, 1);
        chk("toggle_set", toggle_cnt, 1);
        apply(0, 1); ticks(6);
        apply(0, 0); ticks(6);
        mode = 1; drive();
        apply(1, 0); ticks(10);
        apply(0, 0); tick();
        chk("stuck_cnt", err_cnt, 6);
        chk("stuck_sticky", err_sticky, 1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("clr_cnt", err_cnt, 0);
        chk("clr_sticky", err_sticky, 0);
        mode = 0; apply(0, 1); ticks(8);
        apply(1, 1); ticks(8);
        chk("illegal_11", illegal, 1);
        chk("no_err_11", err_cnt, 0);
        apply(0, 1); ticks(8);
        chk("exp_q_after_11", exp_q, 0);
        chk("busy_after_11", busy, 0);
        mode = 2;
        for (int i = 0; i < 7; i++) begin
            apply(i % 2 == 0, i % 2 == 1);
            for (int j = 0; j < 3; j++) begin
                tick();
                chk("busy_toggling", busy, 1);
            end
        end
        mode = 0; apply(0, 1); ticks(8);
        chk("toggle_no_err", err_cnt, 0);
        mode = 2; apply(1, 0); ticks(310);
        chk("sat_cnt", err_cnt, 255);
`ifdef SR_MON_FIRST_ERR_EN
        chk("first_kind_mis", first_err_kind, 1);
`endif
        mode = 0; clr_err = 1'b1; apply(0, 1); tick(); clr_err = 1'b0;
        ticks(8);
        for (int k = 0; k < 60; k++) begin
            mode = ($urandom_range(0, 9) < 8) ? 0 : int'($urandom_range(1, 2));
            clr_err = ($urandom_range(0, 7) == 0);
            apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
            clr_err = 1'b0;
            ticks($urandom_range(0, 9));
        end
        #2 rst_n = 1'b0;
        m_reset();
        #1 check_all();
        @(posedge clk); #1 rst_n = 1'b1;
        m_reset();
        mode = 0;
        for (int k = 0; k < 15; k++) begin
            apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            ticks($urandom_range(1, 8));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sr_latch_monitor.md
Name: sr_latch_monitor

Overview:
Synthesizable response-side checker for the set/reset latch: the observing end of the set/reset stimulus interface. It samples the active-high set/reset drive and the latch's q/qbar, and runs a reference model of the latch. After a settle window it flags mismatches, complement violations and the illegal set+reset condition. It sits beside any latch instance in a bench or on silicon, with error counters and status readable by a host.

Parameters:
SETTLE_CYC, 4, clocks after any stimulus change before checking resumes; legal range 2..255, covering the 2-flop sync latency.
CNT_W, 8, width of err_cnt and toggle_cnt.

Ports:
clk  input  1  single clock; all state on rising edge
rst_n  input  1  asynchronous, active-low reset
set  input  1  active-high set as driven to the latch, before any inversion
reset  input  1  active-high reset as driven to the latch
q  input  1  latch output, asynchronous to clk
qbar  input  1  latch complement output, asynchronous to clk
clr_err  input  1  synchronous clear of err_sticky and err_cnt
busy  output  1  high while in SETTLE
exp_q  output  1  model's expected q
illegal  output  1  high while registered set and reset are both 1
err_pulse  output  1  one-clock pulse per failing check cycle
err_sticky  output  1  set on any error, held until clr_err or reset
err_cnt  output  CNT_W  failing check cycles, saturating at all-ones
toggle_cnt  output  CNT_W  edges seen on synced q, wraps

Behaviour:
- Reset values: q_s=0, qbar_s=1 (2-stage synchronizers), set_r=0, reset_r=0, exp_q=0, exp_valid=1, state=SETTLE, settle counter=SETTLE_CYC, busy=1, illegal=0, err_pulse=0, err_sticky=0, err_cnt=0, toggle_cnt=0.
- Stimulus register: set_r and reset_r are registered each clock. A change is when {set,reset} differs from {set_r,reset_r}.
- Model updates on each clock from set_r/reset_r:
  - 10: exp_q=1, exp_valid=1.
  - 01: exp_q=0, exp_valid=1.
  - 00: hold.
  - 11: exp_q holds, exp_valid=0, illegal=1.
  - exp_valid returns to 1 only on a later 10 or 01.
- FSM:
  - SETTLE: counter decrements each clock. Go to MONITOR when the counter reaches 0.
  - MONITOR: checks run every clock.
  - A change in any state reloads the counter to SETTLE_CYC and enters SETTLE, including a change during SETTLE.
- Checks run in MONITOR only:
  - mismatch = exp_valid & (q_s != exp_q).
  - compl = exp_valid & (q_s == qbar_s). It is skipped while invalid, because the latch legitimately shows q=qbar=1 under 11.
  - fail = mismatch | compl.
- Error outputs:
  - err_pulse is registered: it asserts the clock after the failing compare, one pulse per failing cycle, so a persistent failure gives a continuous high.
  - err_sticky is set by fail.
  - err_cnt increments on fail and saturates at all-ones.
  - clr_err in the same cycle as fail: clear wins that cycle; the next failing cycle counts.
- toggle_cnt increments on every q_s change, in any state including SETTLE, and wraps to 0.
- Latency: a q edge shows in q_s after 2 clocks, and err_pulse one clock after the compare.
- Async reset mid-operation returns every register to its reset value immediately.

Optional Feature:
SR_MON_FIRST_ERR_EN.
- Defined: adds outputs first_err_time[15:0] and first_err_kind[1:0].
  - A free-running cycle counter starts at 0 after reset and saturates at 16'hFFFF.
  - On the first fail after reset or clr_err, it captures that cycle's count and kind (01 mismatch, 10 complement, 11 both).
  - Captured values stay frozen until clr_err or reset clears them to 0.
- Undefined: these ports, the cycle counter and the capture logic do not exist.

Test Plan:
- Reset release, set=reset=0, correct latch with q=0/qbar=1 -> busy low after 4 clocks, err_cnt=0, exp_q=0.
- set=1 for 10 clocks with a correct latch -> exp_q=1, busy high 4 clocks, toggle_cnt=1, no err_pulse.
- Latch model stuck q=0 while set=1 held 10 clocks -> err_pulse high 6 consecutive clocks, err_cnt=6, err_sticky=1; then clr_err -> err_cnt=0, err_sticky=0.
- set=reset=1 -> illegal=1, latch q=qbar=1 raises no error; then reset=1 only -> exp_q=0 and checks resume after 4 clocks.
- Stimulus toggled every 3 clocks for 20 clocks -> busy stays high and err_cnt=0 even with the latch output forced wrong.
- Forced mismatch for 300 clocks with CNT_W=8 -> err_cnt=255 and holds there. With SR_MON_FIRST_ERR_EN defined, first_err_kind=01 and first_err_time equals the first failing cycle.
